// File: rtl/fetch_if.sv
// Bus between the fetch sequencer and its host/decoder: start request,
// per-instruction branch/halt/busy results, and the PC/status outputs.
interface fetch_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic             start;
  logic             halt_instr;
  logic             branch;
  logic [PC_W-1:0]  branch_addr;
  logic             mem_busy;
  logic [PC_W-1:0]  pc;
  logic             instr_valid;
  logic             done;
  logic [CNT_W-1:0] cycle_count;

  // Handshake: start is a level request, taken only in IDLE/DONE. instr_valid
  // qualifies pc for the cycle; halt_instr/branch/branch_addr are meaningful
  // only while instr_valid=1. mem_busy stalls the current instruction.
  modport master (
    output start, halt_instr, branch, branch_addr, mem_busy,
    input  pc, instr_valid, done, cycle_count
  );

  modport slave (
    input  start, halt_instr, branch, branch_addr, mem_busy,
    output pc, instr_valid, done, cycle_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter controller: runs from an accepted start until HALT, follows
// branch results with no bubbles, and holds the PC during data-memory stalls.
module fetch_sequencer #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  fetch_if.slave     bus,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    cnt_d   = cnt_q;

    // Run length saturates rather than wrapping so long programs stay visible.
    if ((state_q == S_RUN || state_q == S_WAIT) && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        pc_d = START_PC;
        if (bus.start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (bus.halt_instr) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (bus.mem_busy) begin
          state_d = S_WAIT;
        end else if (bus.branch) begin
          pc_d = bus.branch_addr;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      S_WAIT: begin
        if (!bus.mem_busy) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          done_d  = 1'b0;
          pc_d    = START_PC;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.instr_valid = (state_q == S_RUN);
  assign bus.done        = done_q;
  assign bus.cycle_count = cnt_q;
  assign dbg_state_o     = state_q;

endmodule
